// File: rtl/finish_time_ctrl_pkg.sv
// Shared types and constants for the finish-time controller.
package finish_time_ctrl_pkg;

    // Top-level controller states
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CONV,
        SHOW
    } state_t;

    localparam int unsigned BCD_W          = 4;
    localparam int unsigned SEC_W          = 7;
    localparam int unsigned CLK_HZ_DEFAULT = 25000000;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter using repeated subtraction of ten.
// A start pulse latches the input. Each following cycle either subtracts ten
// or, once the remainder is below ten, loads the output digits and asserts
// done. Optional macro FINISH_BEST_TIME_EN exposes the pending digits so the
// parent can compare them on the done cycle.
module bin2bcd_seq
    import finish_time_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [SEC_W-1:0] bin,
    output logic             done,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
`ifdef FINISH_BEST_TIME_EN
    ,
    output logic [BCD_W-1:0] pend_tens,
    output logic [BCD_W-1:0] pend_ones
`endif
);

    logic             active_q;
    logic [SEC_W-1:0] rem_q;
    logic [BCD_W-1:0] cnt_q;
    logic [BCD_W-1:0] tens_q;
    logic [BCD_W-1:0] ones_q;

    // Final cycle of a conversion: remainder already below ten
    always_comb begin
        done = active_q && (rem_q < SEC_W'(10));
    end

    // Subtract-ten loop; output digits only change when the loop finishes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            rem_q    <= '0;
            cnt_q    <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
        end else if (start) begin
            active_q <= 1'b1;
            rem_q    <= bin;
            cnt_q    <= '0;
        end else if (active_q) begin
            if (rem_q >= SEC_W'(10)) begin
                rem_q <= rem_q - SEC_W'(10);
                cnt_q <= cnt_q + 1'b1;
            end else begin
                tens_q   <= cnt_q;
                ones_q   <= rem_q[BCD_W-1:0];
                active_q <= 1'b0;
            end
        end
    end

    assign tens = tens_q;
    assign ones = ones_q;

`ifdef FINISH_BEST_TIME_EN
    assign pend_tens = cnt_q;
    assign pend_ones = rem_q[BCD_W-1:0];
`endif

endmodule

// File: rtl/finish_time_ctrl.sv
// Race finish-time controller: counts elapsed seconds while running, then
// converts the final time to two BCD digits for display.
// Optional macro FINISH_BEST_TIME_EN adds best_10s/best_1s tracking the
// lowest finish time seen since reset.
module finish_time_ctrl
    import finish_time_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ  = CLK_HZ_DEFAULT,
    parameter int unsigned MAX_SEC = 99
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             finish,
    input  logic             pause,
    output logic [SEC_W-1:0] elapsed_sec,
    output logic [BCD_W-1:0] digit_10s,
    output logic [BCD_W-1:0] digit_1s,
    output logic             finish_en,
    output logic             busy
`ifdef FINISH_BEST_TIME_EN
    ,
    output logic [BCD_W-1:0] best_10s,
    output logic [BCD_W-1:0] best_1s
`endif
);

    localparam int unsigned      PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_MAX   = SEC_W'(MAX_SEC);

    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [SEC_W-1:0] sec_q, sec_d;
    logic             conv_start;
    logic             conv_done;

    // Finish only counts in RUN and loses to a simultaneous start
    assign conv_start = (state_q == RUN) && finish && !start;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (start) state_d = RUN;
                     else if (finish) state_d = CONV;
            CONV:    if (conv_done) state_d = SHOW;
            SHOW:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        finish_en = (state_q == SHOW);
        busy      = (state_q == CONV);
    end

    // Prescaler and seconds counter next-state; start clears both on RUN entry
    always_comb begin
        presc_d = presc_q;
        sec_d   = sec_q;
        if (start && (state_q != CONV)) begin
            presc_d = '0;
            sec_d   = '0;
        end else if ((state_q == RUN) && !pause) begin
            if (presc_q == PRESC_MAX) begin
                presc_d = '0;
                if (sec_q != SEC_MAX) begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Prescaler and seconds registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            sec_q   <= '0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
        end
    end

    assign elapsed_sec = sec_q;

`ifdef FINISH_BEST_TIME_EN
    logic [BCD_W-1:0] pend_tens;
    logic [BCD_W-1:0] pend_ones;
`endif

    // Converter is fed sec_d so a wrap on the finish cycle is captured
    bin2bcd_seq u_bin2bcd (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (conv_start),
        .bin       (sec_d),
        .done      (conv_done),
        .tens      (digit_10s),
        .ones      (digit_1s)
`ifdef FINISH_BEST_TIME_EN
        ,
        .pend_tens (pend_tens),
        .pend_ones (pend_ones)
`endif
    );

`ifdef FINISH_BEST_TIME_EN
    // Best time: BCD pairs compare correctly as a concatenated value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_10s <= BCD_W'(9);
            best_1s  <= BCD_W'(9);
        end else if ((state_q == CONV) && conv_done &&
                     ({pend_tens, pend_ones} < {best_10s, best_1s})) begin
            best_10s <= pend_tens;
            best_1s  <= pend_ones;
        end
    end
`endif

endmodule

// File: doc/finish_time_ctrl.md
FINISH_TIME_CTRL -- requirements
Module: finish_time_ctrl

Interface
REQ-001 Parameter: CLK_HZ, default 25000000, clock cycles per elapsed second.
REQ-002 Parameter: MAX_SEC, default 99, saturation value of the seconds counter (must be at most 99).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  one-cycle pulse; begins or restarts a timed run.
REQ-006 Port: finish  input  1  one-cycle pulse; player reached goal, stops the run.
REQ-007 Port: pause  input  1  level; freezes time accumulation while high.
REQ-008 Port: elapsed_sec  output  7  live seconds count, binary.
REQ-009 Port: digit_10s  output  4  BCD tens digit of final time.
REQ-010 Port: digit_1s  output  4  BCD ones digit of final time.
REQ-011 Port: finish_en  output  1  high while the final time is valid for display.
REQ-012 Port: busy  output  1  high while in state CONV.

Function
REQ-013 The FSM shall have states IDLE, RUN, CONV and SHOW, with IDLE as the reset state.
REQ-014 Transitions: IDLE-start->RUN; RUN-finish->CONV; RUN-start->RUN with restart; CONV-done->SHOW; SHOW-start->RUN; no other transitions.
REQ-015 On entry to RUN, the prescaler and elapsed_sec shall clear to 0 in the same cycle.
REQ-016 In RUN with pause low, the prescaler shall count 0..CLK_HZ-1; on wrap it shall increment elapsed_sec, saturating at MAX_SEC.
REQ-017 With pause high, the prescaler and elapsed_sec shall hold; pause shall be ignored outside RUN.
REQ-018 If a prescaler wrap and finish occur in the same cycle, the increment shall be counted before capture.
REQ-019 If start and finish are asserted together in RUN, start shall win.
REQ-020 On entry to CONV, the final seconds value shall be latched into a remainder register and the tens counter shall be cleared.
REQ-021 Each CONV cycle: if remainder >= 10, the block shall subtract 10 and increment tens; otherwise it shall load digit_1s=remainder and digit_10s=tens and go to SHOW.
REQ-022 CONV latency shall be floor(sec/10)+1 cycles, with a worst case of 10 cycles at sec=99.
REQ-023 start and finish shall be ignored during CONV.
REQ-024 finish_en shall be 1 only in SHOW; digit outputs shall change only on the CONV->SHOW edge.
REQ-025 Digits shall hold their values through RUN until the next CONV completes.
REQ-026 elapsed_sec shall hold its final value in CONV and SHOW.
REQ-027 In IDLE and SHOW, finish shall be ignored.

Reset
REQ-028 Asserting reset_n low at any time, including mid-CONV, shall force IDLE and clear the prescaler, elapsed_sec, remainder, tens, digit_10s and digit_1s.
REQ-029 While reset is asserted, finish_en=0 and busy=0.
REQ-030 The first start accepted after reset release shall behave exactly as a start in IDLE.

Configuration
REQ-031 With macro FINISH_BEST_TIME_EN defined, the block shall add outputs best_10s[3:0] and best_1s[3:0], reset to 9 and 9.
REQ-032 With FINISH_BEST_TIME_EN defined, on CONV->SHOW the best digits shall update if the new time is strictly less than the best time; equal times shall leave the best unchanged.
REQ-033 With FINISH_BEST_TIME_EN undefined, the best-time ports and logic shall be absent and all other behaviour shall be identical.

Structure
REQ-034 A shared package shall hold the state enum (IDLE/RUN/CONV/SHOW), the BCD digit width (4) and the default CLK_HZ constant.
REQ-035 The repeated-subtraction converter shall be a sub-module, bin2bcd_seq, with handshake start/done, input 7 bits and outputs tens/ones.
REQ-036 The prescaler and the FSM shall reside in finish_time_ctrl.

Verification (CLK_HZ=4 for sim)
REQ-037 Reset scenario: reset_n low then high -> finish_en=0, busy=0, digits 0/0, elapsed_sec=0.
REQ-038 Basic run: start, 37 ticks (148 cycles), finish -> busy for exactly 4 cycles, then digit_10s=3, digit_1s=7, finish_en=1.
REQ-039 Pause: pause high for 40 cycles mid-run -> elapsed_sec unchanged during the pause; final digits exclude the paused time.
REQ-040 Saturation and coincidence: 120 ticks -> elapsed_sec=99, digits 9/9, 10-cycle CONV; finish on a wrap cycle -> the incremented value is captured.
REQ-041 Abort: reset_n pulsed low mid-CONV -> IDLE, digits 0/0; start with finish in the same cycle in RUN -> restart, no CONV.
REQ-042 Best time (FINISH_BEST_TIME_EN defined): runs of 45, 30 and 30 seconds -> best digits 4/5, then 3/0, then 3/0.
